// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: start/halt control, instruction memory port,
// branch redirect input and IF/ID pipeline register outputs.
interface fetch_sequencer_if;
    logic        Start;
    logic        Halt;
    logic [63:0] IMAddress;
    logic [31:0] IMData;
    logic        DecodeReady;
    logic        BranchTaken;
    logic [63:0] BranchTarget;
    logic        IFIDValid;
    logic [31:0] IFIDInstruction;
    logic [63:0] IFIDPC;
    logic [31:0] FetchCount;
    logic        Busy;
    logic        BoundFault;

    modport master (
        input  Start, Halt, IMData, DecodeReady,
        input  BranchTaken, BranchTarget,
        output IMAddress, IFIDValid, IFIDInstruction,
        output IFIDPC, FetchCount, Busy, BoundFault
    );

    modport slave (
        output Start, Halt, IMData, DecodeReady,
        output BranchTaken, BranchTarget,
        input  IMAddress, IFIDValid, IFIDInstruction,
        input  IFIDPC, FetchCount, Busy, BoundFault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, IF/ID load, redirect/squash, halt drain.
// Define PC_BOUND_CHECK_EN to suppress fetches above MEM_LIMIT.
module fetch_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'd0,
    parameter logic [63:0] PC_STEP      = 64'd4,
    parameter logic [63:0] MEM_LIMIT    = 64'd220
) (
    input  logic               CLK,
    input  logic               Reset,
    fetch_sequencer_if.master  fs
);

`ifdef PC_BOUND_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic        valid, valid_n;
    logic [31:0] instr, instr_n;
    logic [63:0] ifpc, ifpc_n;
    logic [31:0] cnt, cnt_n;
    logic        fault, fault_n;

    logic        slot_free;
    logic        oob;
    logic [63:0] target;
    logic        do_br, do_halt, do_oob, do_fetch;

    assign slot_free = !valid || fs.DecodeReady;
    assign target    = {fs.BranchTarget[63:2], 2'b00};
    assign oob       = CHECK_EN && (pc > MEM_LIMIT);

    // Mutually exclusive RUN actions, redirect first.
    assign do_br    = fs.BranchTaken;
    assign do_halt  = !do_br && fs.Halt;
    assign do_oob   = !do_br && !fs.Halt && slot_free && oob;
    assign do_fetch = !do_br && !fs.Halt && slot_free && !oob;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= RESET_VECTOR;
            valid <= 1'b0;
            instr <= 32'd0;
            ifpc  <= 64'd0;
            cnt   <= 32'd0;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            valid <= valid_n;
            instr <= instr_n;
            ifpc  <= ifpc_n;
            cnt   <= cnt_n;
            fault <= fault_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = valid;
        instr_n = instr;
        ifpc_n  = ifpc;
        cnt_n   = cnt;
        fault_n = fault;
        unique case (state)
            IDLE: begin
                if (fs.Start) state_n = RUN;
            end
            RUN: begin
                unique case (1'b1)
                    do_br: begin
                        pc_n    = target;
                        valid_n = 1'b0;
                        state_n = fs.Halt ? HALTED : RUN;
                    end
                    do_halt: begin
                        valid_n = valid && !fs.DecodeReady;
                        state_n = DRAIN;
                    end
                    do_oob: begin
                        valid_n = 1'b0;
                        fault_n = 1'b1;
                        state_n = DRAIN;
                    end
                    do_fetch: begin
                        instr_n = fs.IMData;
                        ifpc_n  = pc;
                        valid_n = 1'b1;
                        pc_n    = pc + PC_STEP;
                        cnt_n   = cnt + 32'd1;
                    end
                    default: ;
                endcase
            end
            DRAIN: begin
                state_n = valid ? DRAIN : HALTED;
                if (fs.BranchTaken) begin
                    pc_n    = target;
                    valid_n = 1'b0;
                end else if (fs.DecodeReady) begin
                    valid_n = 1'b0;
                end
            end
            HALTED: begin
                if (fs.Start) begin
                    state_n = RUN;
                    fault_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign fs.IMAddress       = pc;
    assign fs.IFIDValid       = valid;
    assign fs.IFIDInstruction = instr;
    assign fs.IFIDPC          = ifpc;
    assign fs.FetchCount      = cnt;
    assign fs.Busy            = (state == RUN) || (state == DRAIN);
    assign fs.BoundFault      = CHECK_EN && fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random stimulus,
// all checked against a cycle-level behavioural model.
module tb_fetch_sequencer;

`ifdef PC_BOUND_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_HALTED = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_sequencer_if fs();

    fetch_sequencer dut (
        .CLK   (clk),
        .Reset (rst),
        .fs    (fs)
    );

    logic [31:0] mem [256];
    assign fs.IMData = mem[fs.IMAddress[9:2]];

    int n_vec = 0;
    int n_err = 0;

    int          mode;
    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_instr, m_cnt;
    logic        m_valid, m_fault;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mode    = M_IDLE;
        m_pc    = 64'd0;
        m_ifpc  = 64'd0;
        m_instr = 32'd0;
        m_cnt   = 32'd0;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic model_step();
        logic [63:0] tgt;
        bit          free;
        int          nmode;
        tgt  = fs.BranchTarget & ~64'd3;
        free = !m_valid || fs.DecodeReady;
        nmode = mode;
        case (mode)
            M_IDLE: if (fs.Start) nmode = M_RUN;
            M_RUN: begin
                if (fs.BranchTaken) begin
                    m_pc    = tgt;
                    m_valid = 1'b0;
                    nmode   = fs.Halt ? M_HALTED : M_RUN;
                end else if (fs.Halt) begin
                    if (fs.DecodeReady) m_valid = 1'b0;
                    nmode = M_DRAIN;
                end else if (free) begin
                    if (BCHK && m_pc > 64'd220) begin
                        m_fault = 1'b1;
                        m_valid = 1'b0;
                        nmode   = M_DRAIN;
                    end else begin
                        m_instr = mem[m_pc[9:2]];
                        m_ifpc  = m_pc;
                        m_valid = 1'b1;
                        m_pc    = m_pc + 64'd4;
                        m_cnt   = m_cnt + 32'd1;
                    end
                end
            end
            M_DRAIN: begin
                nmode = m_valid ? M_DRAIN : M_HALTED;
                if (fs.BranchTaken) begin
                    m_pc    = tgt;
                    m_valid = 1'b0;
                end else if (fs.DecodeReady) begin
                    m_valid = 1'b0;
                end
            end
            default: if (fs.Start) begin
                nmode   = M_RUN;
                m_fault = 1'b0;
            end
        endcase
        mode = nmode;
    endtask

    task automatic check_all();
        chk("imaddr", fs.IMAddress, m_pc);
        chk("valid", {63'd0, fs.IFIDValid}, {63'd0, m_valid});
        chk("instr", {32'd0, fs.IFIDInstruction}, {32'd0, m_instr});
        chk("ifpc", fs.IFIDPC, m_ifpc);
        chk("count", {32'd0, fs.FetchCount}, {32'd0, m_cnt});
        chk("busy", {63'd0, fs.Busy},
            {63'd0, (mode == M_RUN) || (mode == M_DRAIN)});
        chk("fault", {63'd0, fs.BoundFault}, {63'd0, m_fault});
    endtask

    task automatic drive(input bit st, input bit hl, input bit dr,
                         input bit br, input logic [63:0] tg);
        fs.Start        = st;
        fs.Halt         = hl;
        fs.DecodeReady  = dr;
        fs.BranchTaken  = br;
        fs.BranchTarget = tg;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        drive(0, 0, 0, 0, 64'd0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_all();
        chk("rst_valid", {63'd0, fs.IFIDValid}, 64'd0);
        chk("rst_imaddr", fs.IMAddress, 64'd0);
        rst = 1'b0;

        // Straight-line fetch of seven words.
        drive(1, 0, 1, 0, 64'd0);
        tick();
        drive(0, 0, 1, 0, 64'd0);
        repeat (7) tick();
        chk("p1_count", {32'd0, fs.FetchCount}, 64'd7);
        chk("p1_ifpc", fs.IFIDPC, 64'd24);

        // Redirect with squash, low bits of the target dropped.
        drive(0, 0, 1, 1, 64'h2F);
        tick();
        chk("p3_squash", {63'd0, fs.IFIDValid}, 64'd0);
        chk("p3_pc", fs.IMAddress, 64'h2C);
        drive(0, 0, 1, 0, 64'd0);
        tick();
        chk("p3_ifpc", fs.IFIDPC, 64'h2C);

        // Halt while decode is stalled, then drain and resume.
        drive(0, 1, 0, 0, 64'd0);
        tick();
        drive(0, 0, 0, 0, 64'd0);
        tick();
        chk("p4_busy", {63'd0, fs.Busy}, 64'd1);
        drive(0, 0, 1, 0, 64'd0);
        tick();
        tick();
        chk("p4_halted", {63'd0, fs.Busy}, 64'd0);
        drive(1, 0, 1, 0, 64'd0);
        tick();
        drive(0, 0, 1, 0, 64'd0);
        tick();
        chk("p4_resume", fs.IFIDPC, 64'h30);

        // Asynchronous reset between edges.
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", {63'd0, fs.IFIDValid}, 64'd0);
        chk("ar_count", {32'd0, fs.FetchCount}, 64'd0);
        chk("ar_imaddr", fs.IMAddress, 64'd0);
        chk("ar_ifpc", fs.IFIDPC, 64'd0);
        chk("ar_busy", {63'd0, fs.Busy}, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Branch beyond the legal memory range.
        drive(1, 0, 1, 0, 64'd0);
        tick();
        drive(0, 0, 1, 1, 64'hE0);
        tick();
        drive(0, 0, 1, 0, 64'd0);
        repeat (4) tick();
        chk("p6_fault", {63'd0, fs.BoundFault}, {63'd0, BCHK});
        chk("p6_busy", {63'd0, fs.Busy}, {63'd0, !BCHK});

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [63:0] tg;
            tg = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                             : 64'($urandom_range(0, 255));
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, tg);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the pipelined ARM core. It owns the program counter, drives the address of the combinational instruction memory and loads the IF/ID pipeline register. It handles decode back-pressure, taken-branch redirect with wrong-path squash, and start/halt sequencing. It sits between the instruction memory and the decode stage, and takes redirects from the branch-resolution stage.

Parameters:
RESET_VECTOR, 64'd0, PC value loaded on reset.
PC_STEP, 64'd4, PC increment per fetched instruction.
MEM_LIMIT, 64'd220, highest legal word base address; used only with PC_BOUND_CHECK_EN.

Ports:
CLK  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Start  input  1  begin or resume fetching (IDLE/HALTED only)
Halt  input  1  request stop of fetching
IMAddress  output  64  instruction memory address; always equals PC (combinational)
IMData  input  32  instruction word returned combinationally for IMAddress
DecodeReady  input  1  decode stage consumes IF/ID this cycle
BranchTaken  input  1  taken-branch redirect from resolution stage
BranchTarget  input  64  redirect address; bits [1:0] forced to 0
IFIDValid  output  1  IF/ID holds a valid instruction
IFIDInstruction  output  32  fetched instruction
IFIDPC  output  64  address of IFIDInstruction
FetchCount  output  32  number of instructions loaded into IF/ID; wraps modulo 2^32
Busy  output  1  state is RUN or DRAIN
BoundFault  output  1  sticky out-of-range fetch flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, any time, including mid-fetch):
  - PC=RESET_VECTOR, state=IDLE.
  - IFIDValid=0, IFIDInstruction=0, IFIDPC=0, FetchCount=0, BoundFault=0, Busy=0.
- Slot free condition: slot_free = !IFIDValid || DecodeReady.
- States: IDLE, RUN, DRAIN, HALTED.
- IDLE:
  - No fetch; PC is held.
  - Start=1 -> RUN at the next edge. Halt and BranchTaken are ignored.
- RUN:
  - slot_free=1: IFIDInstruction<=IMData, IFIDPC<=PC, IFIDValid<=1, PC<=PC+PC_STEP, FetchCount++. Fetch latency is 1 cycle from PC to IF/ID.
  - slot_free=0 (stall): PC and IF/ID hold; FetchCount holds.
  - Start is ignored.
- Branch redirect (RUN or DRAIN) has highest priority:
  - BranchTaken=1: PC<={BranchTarget[63:2],2'b00}, IFIDValid<=0 (squash), no fetch this cycle, FetchCount unchanged. This applies regardless of DecodeReady.
  - First target instruction appears in IF/ID one cycle after the redirect edge.
- Halt=1 in RUN with BranchTaken=0: no fetch this cycle, go to DRAIN.
- Halt=1 and BranchTaken=1 in the same RUN cycle: redirect and squash apply, then go directly to HALTED (IF/ID is empty).
- DRAIN:
  - No fetches.
  - IFIDValid && DecodeReady -> IFIDValid<=0.
  - When IFIDValid=0 at an edge (including at DRAIN entry) -> HALTED.
- HALTED:
  - PC holds.
  - Start=1 -> RUN; resumes at the current PC with no re-fetch of the consumed instruction. BranchTaken is ignored.
- IMAddress = PC in all states.
- PC arithmetic is 64-bit unsigned with natural wrap.

Optional Feature:
Macro PC_BOUND_CHECK_EN.
- Defined:
  - In RUN, a fetch with PC > MEM_LIMIT is suppressed and the state goes to DRAIN.
  - BoundFault<=1 and stays set until Reset or a Start that leaves HALTED.
  - A redirect to an in-range address in the same cycle takes priority and suppresses the fault.
- Not defined: no range check; BoundFault is tied to 0.

Test Plan:
1. Reset, Start pulse, DecodeReady=1 for 7 cycles -> IFIDPC 0,4,...,24 on consecutive cycles; IFIDInstruction matches memory words; FetchCount=7.
2. In RUN with IFIDPC=8 and IFIDValid=1, drop DecodeReady for 3 cycles -> IF/ID, PC=12 and FetchCount all held; fetch resumes at PC 12 when DecodeReady returns.
3. BranchTaken=1 with BranchTarget=0x2F while PC=0x20 -> IFIDValid=0 next cycle, PC=0x2C; following cycle IFIDPC=0x2C; FetchCount is not incremented for the squashed slot.
4. Halt with IFIDValid=1 and DecodeReady=0 for 2 cycles -> state stays DRAIN with Busy=1; DecodeReady=1 -> IFIDValid=0 then HALTED with Busy=0; Start -> fetch resumes at the held PC.
5. Assert Reset asynchronously mid-RUN between clock edges -> all outputs go to reset values immediately; IMAddress=RESET_VECTOR.
6. PC_BOUND_CHECK_EN defined, branch to 0xE0 -> no fetch, BoundFault=1, state reaches HALTED; without the macro, the same fetch loads IF/ID and BoundFault stays 0.
